// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the two-requester ALU arbiter.
//   alu_op_e    - runtime opcode encoding carried on op0/op1
//   arb_state_e - arbiter FSM state encoding
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        OR  = 2'b01,
        SUB = 2'b10,
        XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU shared by both requesters.
//   i_op     - opcode (add, or, subtract a-b, xor)
//   i_a, i_b - operands, WIDTH bits
//   o_result - result modulo 2^WIDTH
//   o_cout   - carry for add, borrow for subtract, 0 otherwise
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit: carry-out for the sum, and for the difference the
    // top bit is set exactly when a < b (two's-complement wrap = borrow).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_cout   = 1'b0;
        case (i_op)
            ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_cout   = w_sum[WIDTH];
            end
            OR: begin
                o_result = i_a | i_b;
            end
            SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_cout   = w_diff[WIDTH];
            end
            default: begin
                o_result = i_a ^ i_b;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter granting one of two requesters access to
// a shared ALU. One operation takes three cycles: IDLE (arbitrate and latch
// operands) -> EXEC (compute) -> RESP (update round-robin pointer).
//   clk, rst_n          - clock, asynchronous active-low reset
//   req0/req1           - level-held requests
//   op0/op1, a0/b0/a1/b1 - opcode and operands per requester
//   gnt0/gnt1           - one-cycle pulse: operands captured
//   done0/done1         - one-cycle pulse: result/cout valid
//   result, cout        - registered ALU outputs, held until next EXEC edge
//   busy                - high whenever the FSM is not IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    arb_state_e       r_state;
    logic             r_rr;
    logic             r_win;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    arb_state_e       w_state_nxt;
    logic             w_rr_nxt;
    logic             w_win_nxt;
    logic             w_pick;
    logic [1:0]       w_op_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_gnt0_nxt;
    logic             w_gnt1_nxt;
    logic             w_done0_nxt;
    logic             w_done1_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_cout_nxt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_cout;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_cout   (w_alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_win    <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_win    <= w_win_nxt;
            r_op     <= w_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_result <= w_result_nxt;
            r_cout   <= w_cout_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_win_nxt    = r_win;
        w_pick       = 1'b0;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_result_nxt = r_result;
        w_cout_nxt   = r_cout;

        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the pointer; otherwise the lone requester.
                    w_pick      = (req0 && req1) ? r_rr : req1;
                    w_win_nxt   = w_pick;
                    w_op_nxt    = w_pick ? op1 : op0;
                    w_a_nxt     = w_pick ? a1  : a0;
                    w_b_nxt     = w_pick ? b1  : b0;
                    w_gnt0_nxt  = ~w_pick;
                    w_gnt1_nxt  = w_pick;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_result_nxt = w_alu_result;
                w_cout_nxt   = w_alu_cout;
                w_done0_nxt  = ~r_win;
                w_done1_nxt  = r_win;
                w_state_nxt  = RESP;
            end
            RESP: begin
                w_rr_nxt    = ~r_win;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign result = r_result;
    assign cout   = r_cout;
    assign busy   = (r_state != IDLE);

endmodule
